// File: rtl/vga_clock_pkg.sv
// Shared types and BCD helpers for the VGA clock time-of-day logic.
package vga_clock_pkg;

  typedef logic [5:0] hrs_bcd_t;  // {tens[1:0], units[3:0]}
  typedef logic [6:0] ms_bcd_t;   // {tens[2:0], units[3:0]}

  localparam logic [7:0] HRS_MAX = 8'h23;
  localparam logic [7:0] MS_MAX  = 8'h59;

  localparam int NUM_BTN = 3;
  localparam int BTN_SEC = 0;
  localparam int BTN_MIN = 1;
  localparam int BTN_HRS = 2;

  typedef enum logic {
    BTN_IDLE = 1'b0,
    BTN_HELD = 1'b1
  } btn_state_t;

  function automatic ms_bcd_t ms_next(ms_bcd_t v);
    if (v == MS_MAX[6:0]) return '0;
    if (v[3:0] == 4'd9) return {v[6:4] + 3'd1, 4'd0};
    return {v[6:4], v[3:0] + 4'd1};
  endfunction

  function automatic hrs_bcd_t hrs_next(hrs_bcd_t v);
    if (v == HRS_MAX[5:0]) return '0;
    if (v[3:0] == 4'd9) return {v[5:4] + 2'd1, 4'd0};
    return {v[5:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One adjust button: 2-flop sync, debounce, IDLE/HELD FSM with auto-repeat.
module button_debounce
  import vga_clock_pkg::*;
#(
  parameter int DB_CYCLES     = 315_000,
  parameter int REPEAT_CYCLES = 7_875_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic inc_pulse
);

  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_CYCLES + 1);

  logic          sync1, sync2, db_level;
  logic [DW-1:0] db_cnt;
  logic [RW-1:0] rep_cnt;
  btn_state_t    state;
  logic          db_hit, db_rise, db_fall;

  // Level flips on the last of DB_CYCLES consecutive differing samples.
  assign db_hit  = (sync2 != db_level) && (db_cnt == DW'(DB_CYCLES - 1));
  assign db_rise = db_hit & sync2;
  assign db_fall = db_hit & ~sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      db_level  <= 1'b0;
      db_cnt    <= '0;
      rep_cnt   <= '0;
      state     <= BTN_IDLE;
      inc_pulse <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      if (sync2 == db_level) begin
        db_cnt <= '0;
      end else if (db_hit) begin
        db_level <= sync2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end

      inc_pulse <= 1'b0;
      case (state)
        BTN_IDLE: begin
          if (db_rise) begin
            state     <= BTN_HELD;
            inc_pulse <= 1'b1;
            rep_cnt   <= '0;
          end
        end
        BTN_HELD: begin
          if (db_fall) begin
            state <= BTN_IDLE;
          end else if (rep_cnt == RW'(REPEAT_CYCLES - 1)) begin
            inc_pulse <= 1'b1;
            rep_cnt   <= '0;
          end else begin
            rep_cnt <= rep_cnt + RW'(1);
          end
        end
        default: state <= BTN_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/vga_clock_timekeeper.sv
// Time-of-day keeper: 1 Hz prescaler, BCD h:m:s with button adjust,
// snapshot registers refreshed only on frame_start for tear-free drawing.
module vga_clock_timekeeper
  import vga_clock_pkg::*;
#(
  parameter int CLK_HZ        = 31_500_000,
  parameter int DB_CYCLES     = 315_000,
  parameter int REPEAT_CYCLES = 7_875_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       adj_hrs,
  input  logic       adj_min,
  input  logic       adj_sec,
  input  logic       frame_start,
  output logic [5:0] hrs,
  output logic [6:0] min,
  output logic [6:0] sec,
  output logic       sec_tick
);

  localparam int PW = $clog2(CLK_HZ);

  logic [PW-1:0]      presc;
  logic               tick, tick_pending, apply_tick, any_inc;
  logic [NUM_BTN-1:0] btn_raw, inc;
  hrs_bcd_t           hrs_q, hrs_d;
  ms_bcd_t            min_q, min_d, sec_q, sec_d;

  assign btn_raw = {adj_hrs, adj_min, adj_sec};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_debounce #(
      .DB_CYCLES    (DB_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_btn (
      .clk      (clk),
      .reset    (reset),
      .btn      (btn_raw[i]),
      .inc_pulse(inc[i])
    );
  end

  assign tick    = (presc == PW'(CLK_HZ - 1));
  assign any_inc = |inc;
  // Adjust pulses own the cycle; a colliding tick waits in tick_pending.
  assign apply_tick = (tick | tick_pending) & ~any_inc;

  always_comb begin
    hrs_d = hrs_q;
    min_d = min_q;
    sec_d = sec_q;
    if (apply_tick) begin
      sec_d = ms_next(sec_q);
      if (sec_q == MS_MAX[6:0]) begin
        min_d = ms_next(min_q);
        if (min_q == MS_MAX[6:0]) hrs_d = hrs_next(hrs_q);
      end
    end else begin
      if (inc[BTN_SEC]) sec_d = ms_next(sec_q);
      if (inc[BTN_MIN]) min_d = ms_next(min_q);
      if (inc[BTN_HRS]) hrs_d = hrs_next(hrs_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc        <= '0;
      sec_tick     <= 1'b0;
      tick_pending <= 1'b0;
      hrs_q        <= '0;
      min_q        <= '0;
      sec_q        <= '0;
      hrs          <= '0;
      min          <= '0;
      sec          <= '0;
    end else begin
      presc    <= tick ? '0 : presc + PW'(1);
      sec_tick <= tick;
      // A new tick landing on a pending one keeps one queued so none are lost.
      if (any_inc) tick_pending <= tick_pending | tick;
      else         tick_pending <= tick_pending & tick;
      hrs_q <= hrs_d;
      min_q <= min_d;
      sec_q <= sec_d;
      if (frame_start) begin
        hrs <= hrs_d;
        min <= min_d;
        sec <= sec_d;
      end
    end
  end

endmodule

// File: doc/vga_clock_timekeeper.md
# vga_clock_timekeeper

Time-of-day controller for the VGA clock. It derives a 1 Hz tick from the pixel clock, keeps hours/minutes/seconds in BCD, and debounces the three user adjust buttons into single-step and auto-repeat increments. It publishes a tear-free snapshot of the time to the drawing datapath, updated only on the frame-start strobe.

## Interface
- `CLK_HZ`, 31_500_000, clk cycles per second; prescaler wraps at CLK_HZ-1.
- `DB_CYCLES`, 315_000, consecutive identical synchronised samples required to accept a button level (10 ms).
- `REPEAT_CYCLES`, 7_875_000, auto-repeat period while a button stays held (4 Hz).
- `clk` in 1: pixel clock, single clock domain.
- `reset` in 1: synchronous, active-high.
- `adj_hrs` in 1: raw async button, increment hours.
- `adj_min` in 1: raw async button, increment minutes.
- `adj_sec` in 1: raw async button, increment seconds.
- `frame_start` in 1: one-cycle pulse at start of vertical blank from the VGA timing generator.
- `hrs` out 6: {tens[1:0], units[3:0]} BCD, 00–23.
- `min` out 7: {tens[2:0], units[3:0]} BCD, 00–59.
- `sec` out 7: {tens[2:0], units[3:0]} BCD, 00–59.
- `sec_tick` out 1: one-cycle pulse, registered copy of the 1 Hz tick.

## Operation
- Prescaler counts 0..CLK_HZ-1. Tick is asserted in the cycle where the count equals CLK_HZ-1, and the count wraps to 0.
- Tick advances the internal time with a full carry chain:
  - sec units 9→0 carries into sec tens.
  - sec 59→00 carries into minutes.
  - min 59→00 carries into hours.
  - hrs units 9→0 carries into hrs tens.
  - hrs 23→00 wraps.
- Each button passes through its own 2-flop synchroniser and debounce counter. The debounced level changes only after DB_CYCLES consecutive samples that differ from the current level. Any mismatch restarts the counter.
- Per-button FSM:
  - IDLE → HELD on debounced rise. Emit an increment pulse on this transition and clear the repeat counter.
  - HELD: emit a pulse each time the repeat counter reaches REPEAT_CYCLES-1, then clear the counter.
  - HELD → IDLE on debounced fall. No pulse.
- Increment pulses act on one field only, with no carry into the next field:
  - adj_sec: 59→00.
  - adj_min: 59→00.
  - adj_hrs: 23→00.
- Simultaneous pulses on different buttons are all applied in the same cycle.
- Tick colliding with any increment pulse: the tick is stored in `tick_pending` and applied on the next cycle with no pulse. Ticks are never lost and never double-applied.
- Display snapshot: the `hrs`/`min`/`sec` outputs load the internal time only in cycles where `frame_start`=1. They hold otherwise.
- Reset: internal time 00:00:00, outputs 0, `sec_tick`=0, prescaler 0, `tick_pending`=0, debounced levels 0, all FSMs IDLE. Reset takes effect mid-press or mid-frame. A button still held after reset generates a fresh press once DB_CYCLES have elapsed.

## Timing
- Button path: raw rise at cycle 0, synchroniser output at cycle 2, debounced level at cycle 2+DB_CYCLES. The increment pulse is in the same cycle as the debounced rise. The internal field updates one cycle later.
- Tick to internal time: 1 cycle. `sec_tick` is high in the cycle after the prescaler wrap.
- `frame_start` to outputs: 1 cycle. Outputs reflect the internal time as of the `frame_start` cycle, including any update committed on that edge.
- Deferred tick: the field updates 2 cycles after the tick instead of 1.

## Structure
- Package `vga_clock_pkg` holds:
  - BCD field typedefs `hrs_bcd_t`, `ms_bcd_t`.
  - Constants HRS_MAX=8'h23 and MS_MAX=8'h59.
  - An enum for the button FSM states.
- Sub-module `button_debounce` (synchroniser, debounce counter, IDLE/HELD FSM, repeat counter; output `inc_pulse`) is instantiated three times.
- Top level holds the prescaler, the BCD counters, `tick_pending` and the snapshot registers.

## Test plan
All scenarios use CLK_HZ=10, DB_CYCLES=4, REPEAT_CYCLES=20, and `frame_start` pulsed every cycle unless noted.
- Reset, then run 600 cycles → `sec` walks 00..59 with one step every 10 cycles. `min`=01 and `sec`=00 after cycle 600. Exactly 60 `sec_tick` pulses are seen.
- Preload 23:59:59 via adj buttons, then one tick → 00:00:00 next cycle. `hrs` tens/units both 0, with no illegal BCD.
- `adj_min` bounced 1-0-1 every cycle for 10 cycles, then held for 45 cycles → exactly 1 increment from the initial press plus 2 repeats. `min` rises by 3, with no carry into `hrs` at the 59→00 wrap.
- Time at xx:xx:09, with an `adj_sec` pulse forced into the same cycle as a tick → `sec`=10 on the next cycle (adjust), then `sec`=11 the cycle after (deferred tick).
- `frame_start` pulsed once every 25 cycles → outputs change only on the cycle after each pulse. `sec` jumps by 2 or 3 between snapshots.
- `reset` asserted while `adj_hrs` is held and the FSM is in HELD → outputs are 0 the next cycle. With the button still held, the first new increment appears exactly 2+DB_CYCLES cycles after reset deasserts.
